// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared types and constants for the machine-mode trap
//                sequencer: FSM state encoding, mtval source select,
//                exception/interrupt cause codes and source bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    // Sequencer states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    // Which value feeds mtval for the winning source.
    typedef enum logic [1:0] {
        TVAL_ZERO    = 2'd0,
        TVAL_PC      = 2'd1,
        TVAL_BADADDR = 2'd2,
        TVAL_INST    = 2'd3
    } tval_sel_t;

    // Exception codes (mcause with interrupt bit clear).
    localparam int unsigned CAUSE_INST_ADDR = 0;
    localparam int unsigned CAUSE_ILLEGAL   = 2;
    localparam int unsigned CAUSE_BREAK     = 3;
    localparam int unsigned CAUSE_LD_ADDR   = 4;
    localparam int unsigned CAUSE_ST_ADDR   = 6;
    localparam int unsigned CAUSE_ECALL_M   = 11;

    // Interrupt codes (mcause with interrupt bit set).
    localparam int unsigned CAUSE_IRQ_SW    = 3;
    localparam int unsigned CAUSE_IRQ_TIM   = 7;
    localparam int unsigned CAUSE_IRQ_EXT   = 11;

    // Bit positions in the exception source vector, highest priority first.
    localparam int unsigned N_EXC         = 6;
    localparam int unsigned EXC_BREAK     = 0;
    localparam int unsigned EXC_INST_ADDR = 1;
    localparam int unsigned EXC_ILLEGAL   = 2;
    localparam int unsigned EXC_ECALL     = 3;
    localparam int unsigned EXC_ST_ADDR   = 4;
    localparam int unsigned EXC_LD_ADDR   = 5;

    // Bit positions in the (already enabled) interrupt vector, highest first.
    localparam int unsigned N_IRQ   = 3;
    localparam int unsigned IRQ_EXT = 0;
    localparam int unsigned IRQ_SW  = 1;
    localparam int unsigned IRQ_TIM = 2;

endpackage
`default_nettype wire

// File: rtl/trap_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : trap_prio_enc
//  Description : Combinational priority encoder for synchronous exceptions
//                and enabled interrupts. Any exception beats any interrupt.
//  Ports       : i_exc      - exception sources, bit order from trap_pkg
//                i_irq      - pending and enabled interrupts
//                o_valid    - some source is active
//                o_is_int   - winner is an interrupt
//                o_cause    - exception/interrupt code of the winner
//                o_tval_sel - mtval source for the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int CAUSE_W = 5
) (
    input  logic [N_EXC-1:0]   i_exc,
    input  logic [N_IRQ-1:0]   i_irq,
    output logic               o_valid,
    output logic               o_is_int,
    output logic [CAUSE_W-1:0] o_cause,
    output tval_sel_t          o_tval_sel
);

    always_comb begin
        o_valid    = 1'b1;
        o_is_int   = 1'b0;
        o_cause    = '0;
        o_tval_sel = TVAL_ZERO;
        if (i_exc[EXC_BREAK]) begin
            o_cause    = CAUSE_W'(CAUSE_BREAK);
            o_tval_sel = TVAL_PC;
        end else if (i_exc[EXC_INST_ADDR]) begin
            o_cause    = CAUSE_W'(CAUSE_INST_ADDR);
            o_tval_sel = TVAL_BADADDR;
        end else if (i_exc[EXC_ILLEGAL]) begin
            o_cause    = CAUSE_W'(CAUSE_ILLEGAL);
            o_tval_sel = TVAL_INST;
        end else if (i_exc[EXC_ECALL]) begin
            o_cause    = CAUSE_W'(CAUSE_ECALL_M);
        end else if (i_exc[EXC_ST_ADDR]) begin
            o_cause    = CAUSE_W'(CAUSE_ST_ADDR);
            o_tval_sel = TVAL_BADADDR;
        end else if (i_exc[EXC_LD_ADDR]) begin
            o_cause    = CAUSE_W'(CAUSE_LD_ADDR);
            o_tval_sel = TVAL_BADADDR;
        end else if (i_irq[IRQ_EXT]) begin
            o_is_int   = 1'b1;
            o_cause    = CAUSE_W'(CAUSE_IRQ_EXT);
        end else if (i_irq[IRQ_SW]) begin
            o_is_int   = 1'b1;
            o_cause    = CAUSE_W'(CAUSE_IRQ_SW);
        end else if (i_irq[IRQ_TIM]) begin
            o_is_int   = 1'b1;
            o_cause    = CAUSE_W'(CAUSE_IRQ_TIM);
        end else begin
            o_valid    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Machine-mode trap entry / MRET sequencer. Arbitrates
//                exceptions, interrupts and MRET in IDLE, stalls and drains
//                the pipeline, issues one commit strobe toward the CSR file
//                and then holds a fetch redirect until it is acknowledged.
//  Ports       : i_ex_*            - execute-stage exception sources / data
//                i_mret            - MRET in execute
//                i_irq_*, i_mie,
//                i_mstatus_mie     - interrupt pending / enable state
//                i_tvec, i_epc     - current mtvec / mepc
//                i_drained         - pipeline empty
//                i_redirect_ack    - fetch took the redirect
//                o_stall, o_flush  - pipeline control
//                o_trap_we/o_mret_we, o_cause/o_epc/o_tval - CSR commit
//                o_redirect_valid/o_redirect_pc - fetch redirect
//  Options     : TRAP_CTRL_VECTORED_EN - honour mtvec vectored mode for
//                interrupts (base + 4*cause). Undefined: direct mode only.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_ebreak,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ex_ecall,
    input  logic            i_ex_st_addr,
    input  logic            i_ex_ld_addr,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [31:0]     i_ex_inst,
    input  logic [XLEN-1:0] i_ex_badaddr,
    input  logic [XLEN-1:0] i_next_pc,
    input  logic            i_irq_ext,
    input  logic            i_irq_sw,
    input  logic            i_irq_tim,
    input  logic            i_mstatus_mie,
    input  logic [2:0]      i_mie,
    input  logic [XLEN-1:0] i_tvec,
    input  logic [XLEN-1:0] i_epc,
    input  logic            i_drained,
    input  logic            i_redirect_ack,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_trap_we,
    output logic            o_mret_we,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_epc,
    output logic [XLEN-1:0] o_tval,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);

    trap_state_t      r_state;
    logic             r_first_drain;
    logic             r_is_mret;
    logic [XLEN-1:0]  r_cause;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_tval;
    logic [XLEN-1:0]  r_out_cause;
    logic [XLEN-1:0]  r_out_epc;
    logic [XLEN-1:0]  r_out_tval;
    logic [XLEN-1:0]  r_redirect_pc;

    logic [N_EXC-1:0]   w_exc;
    logic [N_IRQ-1:0]   w_irq;
    logic               w_enc_valid;
    logic               w_enc_is_int;
    logic [CAUSE_W-1:0] w_enc_cause;
    tval_sel_t          w_enc_tval_sel;
    logic               w_idle;
    logic               w_req;
    logic [XLEN-1:0]    w_cap_cause;
    logic [XLEN-1:0]    w_cap_epc;
    logic [XLEN-1:0]    w_cap_tval;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_target;

    assign w_exc[EXC_BREAK]     = i_ex_ebreak;
    assign w_exc[EXC_INST_ADDR] = i_ex_inst_addr;
    assign w_exc[EXC_ILLEGAL]   = i_ex_illegal;
    assign w_exc[EXC_ECALL]     = i_ex_ecall;
    assign w_exc[EXC_ST_ADDR]   = i_ex_st_addr;
    assign w_exc[EXC_LD_ADDR]   = i_ex_ld_addr;

    // i_mie is {MEIE, MSIE, MTIE}; all interrupts gated by mstatus.MIE.
    assign w_irq[IRQ_EXT] = i_mstatus_mie & i_irq_ext & i_mie[2];
    assign w_irq[IRQ_SW]  = i_mstatus_mie & i_irq_sw  & i_mie[1];
    assign w_irq[IRQ_TIM] = i_mstatus_mie & i_irq_tim & i_mie[0];

    trap_prio_enc #(
        .CAUSE_W (CAUSE_W)
    ) u_prio_enc (
        .i_exc      (w_exc),
        .i_irq      (w_irq),
        .o_valid    (w_enc_valid),
        .o_is_int   (w_enc_is_int),
        .o_cause    (w_enc_cause),
        .o_tval_sel (w_enc_tval_sel)
    );

    assign w_idle = (r_state == ST_IDLE);
    // MRET only wins when no trap source is active.
    assign w_req  = w_enc_valid | i_mret;

    // Capture values; with no trap source (pure MRET) cause and tval are 0.
    always_comb begin
        w_cap_cause                = '0;
        w_cap_cause[CAUSE_W-1:0]   = w_enc_cause;
        w_cap_cause[XLEN-1]        = w_enc_is_int;
        w_cap_epc                  = w_enc_is_int ? i_next_pc : i_ex_pc;
        case (w_enc_tval_sel)
            TVAL_PC:      w_cap_tval = i_ex_pc;
            TVAL_BADADDR: w_cap_tval = i_ex_badaddr;
            TVAL_INST:    w_cap_tval = XLEN'(i_ex_inst);
            default:      w_cap_tval = '0;
        endcase
    end

    assign w_base = {i_tvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
    always_comb begin
        w_target = w_base;
        if (r_is_mret) begin
            w_target = i_epc;
        end else if (r_cause[XLEN-1] && (i_tvec[1:0] == 2'b01)) begin
            w_target = w_base + (XLEN'(r_cause[CAUSE_W-1:0]) << 2);
        end
    end
`else
    // Mode bits are ignored in direct-only builds.
    logic [1:0] w_unused_tvec_mode;
    assign w_unused_tvec_mode = i_tvec[1:0];
    assign w_target = r_is_mret ? i_epc : w_base;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_first_drain <= 1'b0;
            r_is_mret     <= 1'b0;
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_out_cause   <= '0;
            r_out_epc     <= '0;
            r_out_tval    <= '0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_cause       <= w_cap_cause;
                        r_epc         <= w_cap_epc;
                        r_tval        <= w_cap_tval;
                        r_is_mret     <= ~w_enc_valid;
                        r_first_drain <= 1'b1;
                        r_state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_first_drain <= 1'b0;
                    if (i_drained) begin
                        // Commit values only change on entry to COMMIT.
                        r_out_cause <= r_cause;
                        r_out_epc   <= r_epc;
                        r_out_tval  <= r_tval;
                        r_state     <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // Target is frozen here so it stays stable while waiting for ack.
                    r_redirect_pc <= w_target;
                    r_state       <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (i_redirect_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_stall          = ~w_idle | w_req;
    assign o_flush          = (r_state == ST_DRAIN) & r_first_drain;
    assign o_trap_we        = (r_state == ST_COMMIT) & ~r_is_mret;
    assign o_mret_we        = (r_state == ST_COMMIT) & r_is_mret;
    assign o_cause          = r_out_cause;
    assign o_epc            = r_out_epc;
    assign o_tval           = r_out_tval;
    assign o_redirect_valid = (r_state == ST_REDIRECT);
    assign o_redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Directed self-checking bench for trap_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_ebreak, ex_inst_addr, ex_illegal, ex_ecall, ex_st_addr, ex_ld_addr;
    logic        mret;
    logic [31:0] ex_pc, ex_inst, ex_badaddr, next_pc;
    logic        irq_ext, irq_sw, irq_tim, mstatus_mie;
    logic [2:0]  mie;
    logic [31:0] tvec, epc;
    logic        drained, redirect_ack;
    logic        stall, flush, trap_we, mret_we, redirect_valid;
    logic [31:0] cause, epc_o, tval, redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .CAUSE_W(5)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ex_ebreak      (ex_ebreak),
        .i_ex_inst_addr   (ex_inst_addr),
        .i_ex_illegal     (ex_illegal),
        .i_ex_ecall       (ex_ecall),
        .i_ex_st_addr     (ex_st_addr),
        .i_ex_ld_addr     (ex_ld_addr),
        .i_mret           (mret),
        .i_ex_pc          (ex_pc),
        .i_ex_inst        (ex_inst),
        .i_ex_badaddr     (ex_badaddr),
        .i_next_pc        (next_pc),
        .i_irq_ext        (irq_ext),
        .i_irq_sw         (irq_sw),
        .i_irq_tim        (irq_tim),
        .i_mstatus_mie    (mstatus_mie),
        .i_mie            (mie),
        .i_tvec           (tvec),
        .i_epc            (epc),
        .i_drained        (drained),
        .i_redirect_ack   (redirect_ack),
        .o_stall          (stall),
        .o_flush          (flush),
        .o_trap_we        (trap_we),
        .o_mret_we        (mret_we),
        .o_cause          (cause),
        .o_epc            (epc_o),
        .o_tval           (tval),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance until a commit strobe, bounded to 20 cycles.
    task automatic wait_commit(input string tag, output logic [31:0] c, output logic [31:0] e,
                               output logic [31:0] t, output logic was_mret);
        logic found;
        found = 1'b0;
        c = '0; e = '0; t = '0; was_mret = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (trap_we || mret_we) begin
                c = cause; e = epc_o; t = tval; was_mret = mret_we;
                found = 1'b1;
                break;
            end
        end
        check({tag, "_commit_seen"}, {31'd0, found}, 32'd1);
    endtask

    logic [31:0] c_cause, c_epc, c_tval;
    logic        c_mret;
    int          pulses;

    initial begin
        rst = 1'b1;
        ex_ebreak = 0; ex_inst_addr = 0; ex_illegal = 0; ex_ecall = 0; ex_st_addr = 0; ex_ld_addr = 0;
        mret = 0; ex_pc = 0; ex_inst = 0; ex_badaddr = 0; next_pc = 0;
        irq_ext = 0; irq_sw = 0; irq_tim = 0; mstatus_mie = 0; mie = 3'b000;
        tvec = 0; epc = 0; drained = 0; redirect_ack = 0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_stall", {31'd0, stall}, 0);
        check("rst_flush", {31'd0, flush}, 0);
        check("rst_trap_we", {31'd0, trap_we}, 0);
        check("rst_mret_we", {31'd0, mret_we}, 0);
        check("rst_cause", cause, 0);
        check("rst_epc", epc_o, 0);
        check("rst_tval", tval, 0);
        check("rst_rvalid", {31'd0, redirect_valid}, 0);
        check("rst_rpc", redirect_pc, 0);

        // Illegal instruction, best-case latency.
        ex_illegal = 1; ex_pc = 32'h100; ex_inst = 32'hFFFF_FFFF; drained = 1; tvec = 32'h80;
        #1;
        check("ill_stall_n", {31'd0, stall}, 1);
        step(); ex_illegal = 0;
        check("ill_flush_n1", {31'd0, flush}, 1);
        check("ill_stall_n1", {31'd0, stall}, 1);
        check("ill_we_n1", {31'd0, trap_we}, 0);
        step();
        check("ill_we_n2", {31'd0, trap_we}, 1);
        check("ill_cause", cause, 2);
        check("ill_epc", epc_o, 32'h100);
        check("ill_tval", tval, 32'hFFFF_FFFF);
        check("ill_flush_n2", {31'd0, flush}, 0);
        step();
        check("ill_rvalid", {31'd0, redirect_valid}, 1);
        check("ill_rpc", redirect_pc, 32'h80);
        check("ill_we_n3", {31'd0, trap_we}, 0);
        redirect_ack = 1;
        step();
        check("ill_idle_rvalid", {31'd0, redirect_valid}, 0);
        check("ill_idle_stall", {31'd0, stall}, 0);

        // ebreak + st_addr + illegal together: ebreak wins, single pulse.
        ex_ebreak = 1; ex_st_addr = 1; ex_illegal = 1; ex_pc = 32'h200;
        ex_badaddr = 32'h999; ex_inst = 32'h0001_2345;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ex_ebreak = 0; ex_st_addr = 0; ex_illegal = 0;
            if (trap_we) begin
                pulses++; c_cause = cause; c_tval = tval; c_epc = epc_o;
            end
        end
        check("brk_pulses", pulses, 1);
        check("brk_cause", c_cause, 3);
        check("brk_tval", c_tval, 32'h200);
        check("brk_epc", c_epc, 32'h200);

        // ecall beats timer interrupt; interrupt taken on return to IDLE.
        ex_ecall = 1; ex_pc = 32'h300; next_pc = 32'h304;
        irq_tim = 1; mstatus_mie = 1; mie = 3'b001;
        step(); ex_ecall = 0;
        wait_commit("ecall", c_cause, c_epc, c_tval, c_mret);
        check("ecall_cause", c_cause, 11);
        check("ecall_epc", c_epc, 32'h300);
        check("ecall_tval", c_tval, 0);
        wait_commit("tim", c_cause, c_epc, c_tval, c_mret);
        irq_tim = 0;
        check("tim_cause", c_cause, 32'h8000_0007);
        check("tim_epc", c_epc, 32'h304);
        check("tim_tval", c_tval, 0);
        step(); step();

        // MRET with a slow drain.
        redirect_ack = 0; drained = 0; epc = 32'h400; mret = 1; ex_pc = 32'h3F0;
        #1;
        check("mret_stall_n", {31'd0, stall}, 1);
        step(); mret = 0;
        check("mret_flush_n1", {31'd0, flush}, 1);
        step();
        check("mret_flush_n2", {31'd0, flush}, 0);
        check("mret_we_n2", {31'd0, mret_we}, 0);
        step();
        check("mret_we_n3", {31'd0, mret_we}, 0);
        check("mret_stall_n3", {31'd0, stall}, 1);
        drained = 1;
        step();
        check("mret_we_n4", {31'd0, mret_we}, 1);
        check("mret_trap_we_n4", {31'd0, trap_we}, 0);
        step();
        check("mret_rvalid", {31'd0, redirect_valid}, 1);
        check("mret_rpc", redirect_pc, 32'h400);
        step(); step();
        check("mret_rvalid_hold", {31'd0, redirect_valid}, 1);
        check("mret_rpc_hold", redirect_pc, 32'h400);
        redirect_ack = 1;
        step();
        check("mret_rvalid_done", {31'd0, redirect_valid}, 0);

        // MRET with a concurrent exception is the exception.
        mret = 1; ex_ecall = 1; ex_pc = 32'h500;
        step(); mret = 0; ex_ecall = 0;
        wait_commit("mret_ecall", c_cause, c_epc, c_tval, c_mret);
        check("mret_ecall_is_trap", {31'd0, c_mret}, 0);
        check("mret_ecall_cause", c_cause, 11);
        step(); step();

        // Reset while in REDIRECT.
        redirect_ack = 0; ex_ecall = 1; ex_pc = 32'h600; tvec = 32'h80;
        step(); ex_ecall = 0;
        step(); step();
        check("rr_rvalid_pre", {31'd0, redirect_valid}, 1);
        rst = 1;
        step();
        rst = 0;
        #1;
        check("rr_stall", {31'd0, stall}, 0);
        check("rr_flush", {31'd0, flush}, 0);
        check("rr_rvalid", {31'd0, redirect_valid}, 0);
        check("rr_rpc", redirect_pc, 0);
        check("rr_cause", cause, 0);
        check("rr_epc", epc_o, 0);
        check("rr_tval", tval, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (trap_we || mret_we) pulses++;
            step();
        end
        check("rr_no_commit", pulses, 0);

        // External interrupt with vectored mtvec.
        tvec = 32'h1001; irq_ext = 1; mie = 3'b100; mstatus_mie = 1; next_pc = 32'h700;
        wait_commit("ext", c_cause, c_epc, c_tval, c_mret);
        irq_ext = 0;
        check("ext_cause", c_cause, 32'h8000_000B);
        check("ext_epc", c_epc, 32'h700);
        step();
        check("ext_rvalid", {31'd0, redirect_valid}, 1);
`ifdef TRAP_CTRL_VECTORED_EN
        check("ext_rpc", redirect_pc, 32'h102C);
`else
        check("ext_rpc", redirect_pc, 32'h1000);
`endif
        redirect_ack = 1;
        step();
        check("ext_done", {31'd0, redirect_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
